// File: rtl/xge_tx_arb_pkg.sv
// Shared types and widths for the 10GE transmit arbiter.
// Optional per-source packet statistics are enabled with XGE_TX_ARB_STATS_EN.
package xge_tx_arb_pkg;

    localparam int MAX_SRC = 4;
    localparam int PTR_W   = 2;
    localparam int DATA_W  = 64;
    localparam int MOD_W   = 3;
    localparam int CNT_W   = 32;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic              sop;
        logic              eop;
        logic [MOD_W-1:0]  mod;
        logic [DATA_W-1:0] data;
    } beat_t;

endpackage

// File: rtl/xge_rr_arbiter.sv
// Round-robin pick: returns the first requester after last_ptr, wrapping at NUM_SRC.
module xge_rr_arbiter
    import xge_tx_arb_pkg::*;
#(
    parameter int NUM_SRC = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [PTR_W-1:0]   last_ptr,
    output logic [PTR_W-1:0]   winner,
    output logic               valid
);

    localparam int SUM_W = PTR_W + 1;

    logic [MAX_SRC-1:0] req_ext;
    logic [SUM_W-1:0]   cand;

    // Walk from the farthest candidate to the nearest so the nearest requester wins.
    always_comb begin
        req_ext                = '0;
        req_ext[NUM_SRC-1:0]   = req;
        winner                 = '0;
        valid                  = 1'b0;
        cand                   = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand = {1'b0, last_ptr} + SUM_W'(k);
            if (cand >= SUM_W'(NUM_SRC)) begin
                cand = cand - SUM_W'(NUM_SRC);
            end
            if (req_ext[cand[PTR_W-1:0]]) begin
                winner = cand[PTR_W-1:0];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xge_tx_arbiter.sv
// Packet-locked round-robin arbiter feeding the XGE MAC transmit interface.
// Define XGE_TX_ARB_STATS_EN to add per-source packet counters (stat_clr / stat_pkt_cnt).
module xge_tx_arbiter
    import xge_tx_arb_pkg::*;
#(
    parameter int NUM_SRC = 2
) (
    input  logic                    clk_156m25,
    input  logic                    reset_156m25_n,
    input  logic [NUM_SRC-1:0]      src_val,
    input  logic [NUM_SRC-1:0]      src_sop,
    input  logic [NUM_SRC-1:0]      src_eop,
    input  logic [3*NUM_SRC-1:0]    src_mod,
    input  logic [64*NUM_SRC-1:0]   src_data,
    output logic [NUM_SRC-1:0]      src_rdy,
    input  logic                    pkt_tx_full,
    output logic                    pkt_tx_val,
    output logic                    pkt_tx_sop,
    output logic                    pkt_tx_eop,
    output logic [2:0]              pkt_tx_mod,
    output logic [63:0]             pkt_tx_data,
    output logic                    proto_err
`ifdef XGE_TX_ARB_STATS_EN
    ,
    input  logic                    stat_clr,
    output logic [32*NUM_SRC-1:0]   stat_pkt_cnt
`endif
);

    arb_state_e       state_q, state_d;
    logic [PTR_W-1:0] grant_q, grant_d;
    logic [PTR_W-1:0] last_q, last_d;
    logic             first_q, first_d;
    logic             tx_val_q, tx_val_d;
    beat_t            tx_beat_q, tx_beat_d;
    logic             proto_err_q, proto_err_d;

    logic             sel_val;
    beat_t            sel_beat;
    logic             accept;
    logic [PTR_W-1:0] arb_winner;
    logic             arb_valid;

    // Only sources offering a start-of-packet beat may compete for the link.
    xge_rr_arbiter #(
        .NUM_SRC (NUM_SRC)
    ) u_rr (
        .req      (src_val & src_sop),
        .last_ptr (last_q),
        .winner   (arb_winner),
        .valid    (arb_valid)
    );

    always_comb begin
        sel_val  = 1'b0;
        sel_beat = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q == PTR_W'(i)) begin
                sel_val       = src_val[i];
                sel_beat.sop  = src_sop[i];
                sel_beat.eop  = src_eop[i];
                sel_beat.mod  = src_mod[MOD_W*i +: MOD_W];
                sel_beat.data = src_data[DATA_W*i +: DATA_W];
            end
        end
    end

    // Ready follows full combinationally; the MAC FIFO absorbs the one beat in flight.
    always_comb begin
        src_rdy = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (state_q == XFER && !pkt_tx_full && grant_q == PTR_W'(i)) begin
                src_rdy[i] = 1'b1;
            end
        end
    end

    assign accept = (state_q == XFER) && !pkt_tx_full && sel_val;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        first_d     = first_q;
        tx_val_d    = accept;
        tx_beat_d   = accept ? sel_beat : '0;
        proto_err_d = accept && sel_beat.sop && !first_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d = XFER;
                    grant_d = arb_winner;
                    first_d = 1'b1;
                end
            end
            XFER: begin
                if (accept) begin
                    first_d = 1'b0;
                    if (sel_beat.eop) begin
                        state_d = IDLE;
                        last_d  = grant_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            last_q      <= PTR_W'(NUM_SRC - 1);
            first_q     <= 1'b0;
            tx_val_q    <= 1'b0;
            tx_beat_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            first_q     <= first_d;
            tx_val_q    <= tx_val_d;
            tx_beat_q   <= tx_beat_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign pkt_tx_val  = tx_val_q;
    assign pkt_tx_sop  = tx_beat_q.sop;
    assign pkt_tx_eop  = tx_beat_q.eop;
    assign pkt_tx_mod  = tx_beat_q.mod;
    assign pkt_tx_data = tx_beat_q.data;
    assign proto_err   = proto_err_q;

`ifdef XGE_TX_ARB_STATS_EN
    logic [CNT_W*NUM_SRC-1:0] stat_cnt_q, stat_cnt_d;

    // Clear wins over a same-cycle completed packet.
    always_comb begin
        stat_cnt_d = stat_cnt_q;
        if (stat_clr) begin
            stat_cnt_d = '0;
        end else if (accept && sel_beat.eop) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (grant_q == PTR_W'(i)) begin
                    stat_cnt_d[CNT_W*i +: CNT_W] = stat_cnt_q[CNT_W*i +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            stat_cnt_q <= '0;
        end else begin
            stat_cnt_q <= stat_cnt_d;
        end
    end

    assign stat_pkt_cnt = stat_cnt_q;
`endif

endmodule
